// File: rtl/idex_pkg.sv
// Shared constants and types for the elastic ID/EX pipeline stage.
// Control-vector bit positions and the occupancy state encoding live here.
package idex_pkg;

  localparam int CTRL_W          = 7;
  localparam int CTRL_WREGEN     = 0;
  localparam int CTRL_WMEMEN     = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_RS2_SWCH   = 3;
  localparam int CTRL_JAL        = 4;
  localparam int CTRL_JALR       = 5;
  localparam int CTRL_BR         = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } idex_state_e;

  // Total width of one packed beat: control, three XLEN words, rd, funct3, funct7[5], pc.
  function automatic int payload_width(input int xlen, input int pc_w, input int raddr_w);
    return CTRL_W + 3 * xlen + raddr_w + 3 + 1 + pc_w;
  endfunction

endpackage

// File: rtl/idex_slot.sv
// One storage entry of the elastic stage: a valid flag plus a payload word.
// Clearing drops only the valid flag; the payload keeps its last loaded value.
module idex_slot
  import idex_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/idex_elastic_stage.sv
// Elastic ID/EX stage: main entry M drives the outputs, skid entry S absorbs one beat of back-pressure.
// Optional stall counter output is enabled by defining IDEX_STALL_CNT_EN.
module idex_elastic_stage
  import idex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PC_W    = 8,
  parameter int RADDR_W = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [XLEN-1:0]    r1_in,
  input  logic [XLEN-1:0]    r2_in,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [RADDR_W-1:0] wreg_in,
  input  logic [2:0]         func3_in,
  input  logic               func7_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [XLEN-1:0]    r1_out,
  output logic [XLEN-1:0]    r2_out,
  output logic [XLEN-1:0]    imm_out,
  output logic [RADDR_W-1:0] wreg_out,
  output logic [2:0]         func3_out,
  output logic               func7_out,
  output logic [PC_W-1:0]    pc_out
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int PW = payload_width(XLEN, PC_W, RADDR_W);

  logic [PW-1:0]     in_beat;
  logic [PW-1:0]     m_d;
  logic [PW-1:0]     m_q;
  logic [PW-1:0]     s_q;
  logic              m_valid;
  logic              s_valid;
  logic              m_load;
  logic              m_clear;
  logic              s_load;
  logic              s_clear;
  logic              next_full;
  logic              acc;
  logic              pop;
  logic [CTRL_W-1:0] ctrl_q;
  idex_state_e       state;

  assign in_beat = {ctrl_in, r1_in, r2_in, imm_in, wreg_in, func3_in, func7_in, pc_in};

  assign acc = in_valid & in_ready;
  assign pop = m_valid & out_ready;

  always_comb begin
    if (s_valid)      state = FULL;
    else if (m_valid) state = ONE;
    else              state = EMPTY;
  end

  // Flush wins over everything; a beat popped in the same cycle is simply gone.
  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_d       = in_beat;
    next_full = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) m_load = 1'b1;
        end
        ONE: begin
          if (acc && pop) begin
            m_load = 1'b1;
          end else if (acc) begin
            s_load    = 1'b1;
            next_full = 1'b1;
          end else if (pop) begin
            m_clear = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            m_load  = 1'b1;
            m_d     = s_q;
            s_clear = 1'b1;
          end else begin
            next_full = 1'b1;
          end
        end
        default: begin
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  idex_slot #(.W(PW)) u_main (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

  idex_slot #(.W(PW)) u_skid (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_beat),
    .valid (s_valid),
    .q     (s_q)
  );

  // Registered ready keeps out_ready off any combinational path to in_ready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) in_ready <= 1'b0;
    else        in_ready <= ~next_full;
  end

  assign {ctrl_q, r1_out, r2_out, imm_out, wreg_out, func3_out, func7_out, pc_out} = m_q;
  assign out_valid = m_valid;
  assign ctrl_out  = m_valid ? ctrl_q : '0;

`ifdef IDEX_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_elastic_stage.sv
// Scoreboard bench for idex_elastic_stage (XLEN=32, PC_W=12); stall counter checks follow IDEX_STALL_CNT_EN.
module tb_idex_elastic_stage;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  wreg;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] pc;
  } beat_t;

  logic        CLK;
  logic        RST_N;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  ctrl_in;
  logic [31:0] r1_in;
  logic [31:0] r2_in;
  logic [31:0] imm_in;
  logic [4:0]  wreg_in;
  logic [2:0]  func3_in;
  logic        func7_in;
  logic [11:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  ctrl_out;
  logic [31:0] r1_out;
  logic [31:0] r2_out;
  logic [31:0] imm_out;
  logic [4:0]  wreg_out;
  logic [2:0]  func3_out;
  logic        func7_out;
  logic [11:0] pc_out;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_stall;
`endif

  int    tests_run;
  int    tests_failed;
  logic  mon_en;
  beat_t sb[$];

  idex_elastic_stage #(.XLEN(32), .PC_W(12), .RADDR_W(5)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_in   (ctrl_in),
    .r1_in     (r1_in),
    .r2_in     (r2_in),
    .imm_in    (imm_in),
    .wreg_in   (wreg_in),
    .func3_in  (func3_in),
    .func7_in  (func7_in),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_out  (ctrl_out),
    .r1_out    (r1_out),
    .r2_out    (r2_out),
    .imm_out   (imm_out),
    .wreg_out  (wreg_out),
    .func3_out (func3_out),
    .func7_out (func7_out),
    .pc_out    (pc_out)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic beat_t makeBeat(input logic [11:0] pc);
    beat_t b;
    b.ctrl = pc[6:0] ^ 7'h2A;
    b.r1   = {20'hC0FFE, pc};
    b.r2   = {pc, 20'h12345};
    b.imm  = {20'hFFFFF, pc ^ 12'hA5A};
    b.wreg = pc[4:0] ^ 5'h1F;
    b.f3   = pc[2:0];
    b.f7   = pc[3];
    b.pc   = pc;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, then advance to the next edge + 1.
  task automatic applyStimulus(input beat_t b, input logic v, input logic r, input logic f);
    ctrl_in   = b.ctrl;
    r1_in     = b.r1;
    r2_in     = b.r2;
    imm_in    = b.imm;
    wreg_in   = b.wreg;
    func3_in  = b.f3;
    func7_in  = b.f7;
    pc_in     = b.pc;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare DUT against the scoreboard, then account for this cycle's handshakes.
  always @(negedge CLK) begin
    beat_t got;
    beat_t cur;
    if (!RST_N) begin
      sb.delete();
`ifdef IDEX_STALL_CNT_EN
      exp_stall = '0;
`endif
    end else if (mon_en) begin
      got = {ctrl_out, r1_out, r2_out, imm_out, wreg_out, func3_out, func7_out, pc_out};
      cur = {ctrl_in, r1_in, r2_in, imm_in, wreg_in, func3_in, func7_in, pc_in};
      checkOutput("out_valid", 128'(out_valid), 128'(sb.size() > 0));
      checkOutput("in_ready", 128'(in_ready), 128'(sb.size() < 2));
      if (sb.size() > 0 && out_valid) checkOutput("beat", 128'(got), 128'(sb[0]));
      else if (!out_valid) checkOutput("bubble_ctrl", 128'(ctrl_out), 128'(0));
`ifdef IDEX_STALL_CNT_EN
      checkOutput("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
      if (flush) exp_stall = '0;
      else if (out_valid && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  initial begin
    beat_t idle;
    beat_t b;
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
`ifdef IDEX_STALL_CNT_EN
    exp_stall    = '0;
`endif
    idle      = makeBeat(12'h000);
    RST_N     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctrl_in   = '0;
    r1_in     = '0;
    r2_in     = '0;
    imm_in    = '0;
    wreg_in   = '0;
    func3_in  = '0;
    func7_in  = 1'b0;
    pc_in     = '0;
    #1 RST_N = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_ctrl_out", 128'(ctrl_out), 128'(0));
    checkOutput("rst_pc_out", 128'(pc_out), 128'(0));
    checkOutput("rst_r1_out", 128'(r1_out), 128'(0));
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    checkOutput("rst_release_ready_low", 128'(in_ready), 128'(0));
    @(posedge CLK);
    #1;
    checkOutput("rst_release_ready", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) applyStimulus(makeBeat(12'h010 + 12'(i)), 1'b1, 1'b1, 1'b0);
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);

    applyStimulus(makeBeat(12'h020), 1'b1, 1'b0, 1'b0);
    applyStimulus(makeBeat(12'h021), 1'b1, 1'b0, 1'b0);
    checkOutput("full_in_ready", 128'(in_ready), 128'(0));
    applyStimulus(idle, 1'b0, 1'b0, 1'b0);
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);

    applyStimulus(makeBeat(12'h022), 1'b1, 1'b0, 1'b0);
    applyStimulus(makeBeat(12'h023), 1'b1, 1'b0, 1'b0);
    applyStimulus(makeBeat(12'h030), 1'b1, 1'b0, 1'b1);
    checkOutput("flush_out_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_ctrl_out", 128'(ctrl_out), 128'(0));
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);

    b      = makeBeat(12'h040);
    b.ctrl = 7'h01;
    b.r1   = 32'hDEAD_BEEF;
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(idle, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_r1", 128'(r1_out), 128'(32'hDEAD_BEEF));
    checkOutput("hold_ctrl", 128'(ctrl_out), 128'(7'h01));
`ifdef IDEX_STALL_CNT_EN
    checkOutput("hold_stall_cnt", 128'(stall_cnt), 128'(5));
`endif
    applyStimulus(idle, 1'b0, 1'b1, 1'b0);

    applyStimulus(makeBeat(12'h050), 1'b1, 1'b0, 1'b0);
    applyStimulus(makeBeat(12'h051), 1'b1, 1'b0, 1'b0);
    mon_en   = 1'b0;
    in_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("async_rst_ctrl_out", 128'(ctrl_out), 128'(0));
    checkOutput("async_rst_in_ready", 128'(in_ready), 128'(0));
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("async_rst_release_ready", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(makeBeat(12'($urandom)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(idle, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
